fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the RISC-V core; replaces the
//  single-cycle "pc + 4 / pc + imm" PC mux. Owns the fetch PC, issues one
//  request at a time to instruction memory and buffers returned words with
//  their PCs in a DEPTH-entry FIFO for decode. Execute redirects it on
//  taken branch/jump, which flushes the FIFO and any in-flight response.
// PARAMETERS
//  XLEN      32  PC and instruction width (bits)
//  DEPTH     4   fetch FIFO entries; power of two, >= 2
//  RESET_PC  0   fetch PC after reset
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst             in   1     asynchronous, active-low reset
//  redirect_valid  in   1     execute: taken branch/jump this cycle
//  redirect_pc     in   XLEN  new fetch PC; bits [1:0] ignored (forced 0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address (= fetch PC)
//  imem_rsp_valid  in   1     response word valid (always accepted, no ready)
//  imem_rsp_inst   in   XLEN  response instruction word
//  dec_valid       out  1     FIFO head valid
//  dec_ready       in   1     decode consumes head
//  dec_inst        out  XLEN  head instruction
//  dec_pc          out  XLEN  head PC
//  dec_jal_pred    out  1     head is a JAL already followed by fetch
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0;
//    imem_req_valid=0, dec_valid=0, dec_jal_pred=0, imem_req_addr=RESET_PC.
//  - Issue: imem_req_valid = !redirect_valid & (!outstanding | imem_rsp_valid)
//    & (count + outstanding < DEPTH) [& !jal_hit when FETCH_JAL_PREDICT_EN].
//    Handshake (valid & ready): req_pc<=fetch_pc, fetch_pc+=4 (wraps mod
//    2^XLEN), outstanding<=1. valid may drop without ready (no hold rule).
//  - Response: clears outstanding. If drop=1, word discarded and drop<=0;
//    else {req_pc, inst} pushed. rsp with outstanding=0 ignored.
//  - Latency: request accepted cycle N, rsp cycle N+k -> dec_valid from N+k+1.
//    With k=1 and dec_ready=1: one instruction per cycle sustained.
//  - Decode: dec_valid = count!=0; pop on dec_valid & dec_ready.
//    Push and pop same cycle: count unchanged. Push never overflows
//    (slot reserved at issue). Pointers wrap modulo DEPTH.
//  - Redirect (priority over all): FIFO count/pointers cleared (pop that
//    cycle ignored), fetch_pc<=redirect_pc & ~3; no request issued that
//    cycle; rsp arriving same cycle discarded; if outstanding and no rsp that
//    cycle, drop<=1. Redirect during drop=1: drop stays 1 (single rsp owed).
//  - Reset asserted mid-operation: all state cleared immediately; a late
//    response after release is ignored (outstanding=0).
// CONFIGURATION
//  FETCH_JAL_PREDICT_EN defined:
//    - jal_hit = accepted (non-dropped) rsp with inst[6:0]=7'b1101111.
//    - Word pushed with pred=1; fetch_pc <= req_pc + sign-extended J-imm
//      {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
//    - No request issued in the jal_hit cycle; redirect_valid same cycle wins.
//    - dec_jal_pred = head pred bit; execute suppresses redirect for it.
//  Not defined: no predecode, pred bit absent, dec_jal_pred tied 0;
//    JAL handled only via redirect.
// TESTING
//  1 Reset release, imem 1-cycle, ready=1, dec_ready=1 -> addrs 0,4,8,..;
//    dec_pc 0,4,8 on consecutive cycles from cycle 3.
//  2 dec_ready=0, DEPTH=4 -> 4 words buffered, imem_req_valid stays 0;
//    dec_ready=1 -> heads PC 0,4,8,C in order, fetch resumes at 0x10.
//  3 Redirect to 0x103 with 3-cycle imem, request in flight -> next addr
//    0x100, stale word dropped, first dec_pc=0x100, FIFO empty before it.
//  4 Redirect same cycle as rsp and dec pop, count=2 -> count=0, no push,
//    imem_req_valid=0 that cycle, next request addr = redirect_pc.
//  5 fetch_pc=0xFFFFFFFC accepted -> next addr 0x00000000.
//  6 FETCH_JAL_PREDICT_EN, word at 0x20 = JAL +0x40 -> next addr 0x60,
//    dec_jal_pred=1 for pc 0x20; macro off -> next addr 0x24, pred=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem request in flight and
// buffers returned words with their PCs for decode. Define FETCH_JAL_PREDICT_EN to follow JALs.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_inst,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc,
    output logic            dec_jal_pred
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW:0]   DepthCnt = (CntW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic            rsp_fire;
    logic            rsp_accept;
    logic            push;
    logic            pop;
    logic            req_fire;
    logic            has_room;
    logic            jal_hit;
    logic [XLEN-1:0] jal_target;
    logic [CntW:0]   reserved;

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [6:0] OpJal = 7'b1101111;

    logic [DEPTH-1:0] pred_mem;
    logic [XLEN-1:0]  jal_imm;

    assign jal_imm = {{(XLEN - 20){imem_rsp_inst[31]}}, imem_rsp_inst[19:12],
                      imem_rsp_inst[20], imem_rsp_inst[30:21], 1'b0};
    assign jal_hit      = rsp_accept & (imem_rsp_inst[6:0] == OpJal);
    assign jal_target   = req_pc_q + jal_imm;
    assign dec_jal_pred = dec_valid & pred_mem[rd_ptr_q];
`else
    assign jal_hit      = 1'b0;
    assign jal_target   = '0;
    assign dec_jal_pred = 1'b0;
`endif

    // A response is only meaningful while a request is owed; stray ones are ignored.
    assign rsp_fire   = imem_rsp_valid & outstanding_q;
    assign rsp_accept = rsp_fire & ~drop_q & ~redirect_valid;
    assign push       = rsp_accept;
    assign pop        = dec_valid & dec_ready & ~redirect_valid;

    // Count the in-flight word as occupied so a push can never overflow the FIFO.
    assign reserved = {1'b0, count_q} + {{CntW{1'b0}}, outstanding_q};
    assign has_room = reserved < DepthCnt;

    assign imem_req_valid = rst & ~redirect_valid & (~outstanding_q | imem_rsp_valid) &
                            has_room & ~jal_hit;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign imem_req_addr  = fetch_pc_q;

    assign dec_valid = (count_q != '0);
    assign dec_inst  = inst_mem[rd_ptr_q];
    assign dec_pc    = pc_mem[rd_ptr_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q + CntW'(push) - CntW'(pop);

        if (rsp_fire) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
        if (req_fire) begin
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            outstanding_d = 1'b1;
        end
        if (jal_hit) begin
            fetch_pc_d = jal_target;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        // Redirect wins over everything; a still-owed response must be swallowed later.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (outstanding_q && !imem_rsp_valid) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rsp_inst;
            pc_mem[wr_ptr_q]   <= req_pc_q;
`ifdef FETCH_JAL_PREDICT_EN
            pred_mem[wr_ptr_q] <= jal_hit;
`endif
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        push |-> (count_q < CntW'(DEPTH)));
    a_count_bound : assert property (@(posedge clk) disable iff (!rst)
        count_q <= CntW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit: an imem model answers requests and a
// scoreboard of the expected program-order instruction stream is checked at decode.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] JalWord  = 32'h0400_006F; // jal x0, +0x40
    localparam logic [31:0] NoAddr   = 32'hDEAD_BEEF;
`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_inst = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_jal_pred;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_inst  (imem_rsp_inst),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_jal_pred   (dec_jal_pred)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] seg_pc = RESET_PC;
    logic [31:0] fire_log[$];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    bit          jal_word_en = 1'b0;

    // imem model: at most one response owed
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    bit          g_redirect = 1'b0;
    logic [31:0] g_redirect_pc = '0;
    bit          g_ready = 1'b0;
    bit          g_dec_ready = 1'b0;
    int          g_lat_min = 1;
    int          g_lat_max = 1;

    function automatic logic [31:0] inst_at(input logic [31:0] pc);
        if (jal_word_en && pc == 32'h20) return JalWord;
        return {pc[26:2] ^ 25'h0AB_CDEF, 7'h13};
    endfunction

    function automatic logic [31:0] jal_offset(input logic [31:0] w);
        logic [20:0] imm;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return {{11{imm[20]}}, imm};
    endfunction

    function automatic logic [31:0] next_after(input logic [31:0] a);
        for (int i = 0; i + 1 < fire_log.size(); i++) begin
            if (fire_log[i] == a) return fire_log[i+1];
        end
        return NoAddr;
    endfunction

    function automatic logic [31:0] fire_at(input int i);
        if (i < fire_log.size()) return fire_log[i];
        return NoAddr;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Program-order stream from seg_pc: sequential, or jumping when a JAL is followed.
    task automatic topup();
        while (exp_q.size() < 12) begin
            exp_t e;
            e.pc   = seg_pc;
            e.inst = inst_at(seg_pc);
            e.pred = JAL_EN && (e.inst[6:0] == 7'b1101111);
            exp_q.push_back(e);
            seg_pc = e.pred ? seg_pc + jal_offset(e.inst) : seg_pc + 32'd4;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_inst  = inst_at(pend_addr);
                pend           = 1'b0;
            end
        end
        redirect_valid = g_redirect;
        redirect_pc    = g_redirect_pc;
        imem_req_ready = g_ready;
        dec_ready      = g_dec_ready;
        if (g_redirect) begin
            exp_q.delete();
            seg_pc = g_redirect_pc & ~32'h3;
        end
        topup();
        #1;
        if (redirect_valid) chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            chk("single_outstanding", 32'(pend), 32'd0);
            fire_log.push_back(imem_req_addr);
            pend      = 1'b1;
            pend_cnt  = int'($urandom_range(g_lat_max, g_lat_min));
            pend_addr = imem_req_addr;
        end
    endtask

    task automatic do_reset(input bit keep_pend);
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
        g_redirect     = 1'b0;
        if (!keep_pend) pend = 1'b0;
        exp_q.delete();
        seg_pc = RESET_PC;
        fire_log.delete();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_jal_pred", 32'(dec_jal_pred), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every decode handshake must match the next expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && dec_valid && dec_ready && !redirect_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dec_unexpected: got pc %h, expected no word", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_inst", dec_inst, e.inst);
                    chk("dec_jal_pred", 32'(dec_jal_pred), 32'(e.pred));
                end
            end
        end
    end

    initial begin
        int n;
        int pops_before;

        // Streaming with 1-cycle memory
        do_reset(1'b0);
        g_ready = 1'b1; g_dec_ready = 1'b1; g_lat_min = 1; g_lat_max = 1;
        cycle(); chk("t1_dec_valid_c0", 32'(dec_valid), 32'd0);
        cycle(); chk("t1_dec_valid_c1", 32'(dec_valid), 32'd0);
        cycle(); chk("t1_dec_valid_c2", 32'(dec_valid), 32'd1);
        chk("t1_first_pc", dec_pc, RESET_PC);
        n = 0;
        repeat (20) begin
            cycle();
            if (dec_valid) n++;
        end
        chk("t1_throughput", 32'(n), 32'd20);
        chk("t1_addr1", fire_at(1), 32'h4);
        chk("t1_addr2", fire_at(2), 32'h8);

        // Decode back-pressure fills the FIFO
        do_reset(1'b0);
        g_ready = 1'b1; g_dec_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_fires", 32'(fire_log.size()), 32'd4);
        chk("t2_req_stalled", 32'(imem_req_valid), 32'd0);
        chk("t2_dec_valid", 32'(dec_valid), 32'd1);
        g_dec_ready = 1'b1;
        repeat (8) cycle();
        chk("t2_resume_addr", fire_at(4), 32'h10);

        // Redirect with a request in flight on a 3-cycle memory
        do_reset(1'b0);
        g_ready = 1'b1; g_dec_ready = 1'b1; g_lat_min = 3; g_lat_max = 3;
        cycle();
        g_redirect = 1'b1; g_redirect_pc = 32'h103;
        cycle();
        g_redirect = 1'b0;
        cycle(); chk("t3_fifo_empty", 32'(dec_valid), 32'd0);
        repeat (10) cycle();
        chk("t3_redirect_addr", fire_at(1), 32'h100);

        // Redirect colliding with a response and a pop while two words are buffered
        do_reset(1'b0);
        g_ready = 1'b1; g_dec_ready = 1'b0; g_lat_min = 1; g_lat_max = 1;
        repeat (3) cycle();
        g_redirect = 1'b1; g_redirect_pc = 32'h200; g_dec_ready = 1'b1;
        cycle(); chk("t4_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("t4_req_blocked", 32'(imem_req_valid), 32'd0);
        g_redirect = 1'b0;
        cycle(); chk("t4_fifo_cleared", 32'(dec_valid), 32'd0);
        repeat (6) cycle();
        chk("t4_next_addr", fire_at(3), 32'h200);

        // Fetch PC wraps at the top of the address space
        do_reset(1'b0);
        g_redirect = 1'b1; g_redirect_pc = 32'hFFFF_FFF8;
        cycle();
        g_redirect = 1'b0;
        repeat (10) cycle();
        chk("t5_wrap_addr", next_after(32'hFFFF_FFFC), 32'h0);

        // JAL at 0x20
        do_reset(1'b0);
        jal_word_en = 1'b1;
        g_redirect = 1'b1; g_redirect_pc = 32'h18;
        cycle();
        g_redirect = 1'b0;
        repeat (12) cycle();
        chk("t6_after_jal_addr", next_after(32'h20), JAL_EN ? 32'h60 : 32'h24);
        jal_word_en = 1'b0;

        // Reset mid-request: the late response must not reach decode
        do_reset(1'b0);
        g_lat_min = 3; g_lat_max = 3;
        cycle();
        do_reset(1'b1);
        g_ready = 1'b0; g_dec_ready = 1'b1;
        repeat (3) cycle();
        chk("t7_late_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        cycle(); chk("t7_late_rsp_ignored", 32'(dec_valid), 32'd0);
        g_ready = 1'b1;
        repeat (10) cycle();

        // Random traffic
        do_reset(1'b0);
        g_lat_min = 1; g_lat_max = 3;
        pops_before = pops;
        repeat (3000) begin
            g_ready       = ($urandom_range(3, 0) != 0);
            g_dec_ready   = ($urandom_range(9, 0) < 7);
            g_redirect    = ($urandom_range(31, 0) == 0);
            g_redirect_pc = $urandom();
            cycle();
        end
        g_redirect = 1'b0;
        chk("rand_progress", 32'(pops - pops_before > 300), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
